systolic_feeder: RTL

//   Upstream operand sequencer for the 2x2 systolic_array. Captures a 2x2 A and 2x2 B matrix
//   on a start handshake, then emits the diagonally skewed, zero-padded operand stream into
//   the array's row (a) and column (b) inputs with a valid strobe. After the stream it drains
//   the array and pulses done once the products are final.

---
 rtl/systolic_feeder.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// ============================================================================
// systolic_feeder
// ----------------------------------------------------------------------------
// Operand sequencer that sits upstream of the 2x2 systolic_array.
// It captures a 2x2 A and a 2x2 B matrix on a start handshake. It then
// emits the diagonally skewed, zero-padded operand stream into the array's
// row (a) and column (b) inputs, with a valid/advance strobe. Next it flushes
// the PE pipeline with zero beats, and finally pulses done once the products
// in the array are final.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous active-low reset (0 = reset)
//   start      : job request, accepted when start && ready
//   mat_a      : {A11,A10,A01,A00}, A00 in the LSBs, sampled on acceptance
//   mat_b      : {B11,B10,B01,B00}, B00 in the LSBs, sampled on acceptance
//   stall      : freezes the beat stream while high (FEED*/DRAIN only)
//   ready      : high only while idle and able to accept
//   acc_clear  : one-cycle pulse that clears the array accumulators
//   a_out_0/1  : operands for array rows 0 and 1
//   b_out_0/1  : operands for array columns 0 and 1
//   valid_out  : array advance strobe
//   busy       : high whenever a job is in flight
//   done       : one-cycle completion pulse
// ============================================================================
module systolic_feeder #(
   parameter int DATA_W       = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DATA_W-1:0]   mat_a,
   input  logic [4*DATA_W-1:0]   mat_b,
   input  logic                  stall,
   output logic                  ready,
   output logic                  acc_clear,
   output logic [DATA_W-1:0]     a_out_0,
   output logic [DATA_W-1:0]     a_out_1,
   output logic [DATA_W-1:0]     b_out_0,
   output logic [DATA_W-1:0]     b_out_1,
   output logic                  valid_out,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED0,
      FEED1,
      FEED2,
      DRAIN,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     drainCnt_q, drainCnt_d;
   logic [4*DATA_W-1:0]  matA_q, matA_d;
   logic [4*DATA_W-1:0]  matB_q, matB_d;

   logic [DATA_W-1:0]    aOut0_q, aOut0_d;
   logic [DATA_W-1:0]    aOut1_q, aOut1_d;
   logic [DATA_W-1:0]    bOut0_q, bOut0_d;
   logic [DATA_W-1:0]    bOut1_q, bOut1_d;
   logic                 valid_q, valid_d;
   logic                 clear_q, clear_d;
   logic                 done_q, done_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;

   logic                 accept;

   // Individual matrix elements of the captured job, named as in the
   // mathematical layout so the skew table below reads directly.
   logic [DATA_W-1:0]    a00, a01, a10, a11;
   logic [DATA_W-1:0]    b00, b01, b10, b11;

   assign a00 = matA_q[0*DATA_W +: DATA_W];
   assign a01 = matA_q[1*DATA_W +: DATA_W];
   assign a10 = matA_q[2*DATA_W +: DATA_W];
   assign a11 = matA_q[3*DATA_W +: DATA_W];
   assign b00 = matB_q[0*DATA_W +: DATA_W];
   assign b01 = matB_q[1*DATA_W +: DATA_W];
   assign b10 = matB_q[2*DATA_W +: DATA_W];
   assign b11 = matB_q[3*DATA_W +: DATA_W];

   // A request is taken only while idle and while the registered ready
   // flag is visible to the requester. This keeps the handshake honest
   // across the reset release and the DONE cycle.
   assign accept = start && ready_q && (state_q == IDLE);

   // Next-state and next-output logic. Every output is a register, so
   // whatever is computed here from the current state shows up on the pins
   // one edge later. While stalled in a feeding state, the operand
   // registers keep their current value, the strobe drops and the
   // sequencer position freezes. The array therefore never sees a beat
   // twice.
   always_comb begin
      state_d    = state_q;
      drainCnt_d = drainCnt_q;
      matA_d     = matA_q;
      matB_d     = matB_q;
      aOut0_d    = aOut0_q;
      aOut1_d    = aOut1_q;
      bOut0_d    = bOut0_q;
      bOut1_d    = bOut1_q;
      valid_d    = 1'b0;
      clear_d    = 1'b0;
      done_d     = 1'b0;
      ready_d    = 1'b0;
      busy_d     = 1'b1;

      case (state_q)
         IDLE: begin
            aOut0_d = '0;
            aOut1_d = '0;
            bOut0_d = '0;
            bOut1_d = '0;
            ready_d = !accept;
            busy_d  = accept;
            if (accept) begin
               matA_d  = mat_a;
               matB_d  = mat_b;
               state_d = CLEAR;
            end
         end

         CLEAR: begin
            aOut0_d = '0;
            aOut1_d = '0;
            bOut0_d = '0;
            bOut1_d = '0;
            clear_d = 1'b1;
            state_d = FEED0;
         end

         FEED0: begin
            if (!stall) begin
               aOut0_d = a00;
               aOut1_d = '0;
               bOut0_d = b00;
               bOut1_d = '0;
               valid_d = 1'b1;
               state_d = FEED1;
            end
         end

         FEED1: begin
            if (!stall) begin
               aOut0_d = a01;
               aOut1_d = a10;
               bOut0_d = b10;
               bOut1_d = b01;
               valid_d = 1'b1;
               state_d = FEED2;
            end
         end

         FEED2: begin
            if (!stall) begin
               aOut0_d    = '0;
               aOut1_d    = a11;
               bOut0_d    = '0;
               bOut1_d    = b11;
               valid_d    = 1'b1;
               drainCnt_d = DRAIN_LOAD;
               state_d    = DRAIN;
            end
         end

         DRAIN: begin
            if (!stall) begin
               aOut0_d = '0;
               aOut1_d = '0;
               bOut0_d = '0;
               bOut1_d = '0;
               valid_d = 1'b1;
               if (drainCnt_q == '0) begin
                  state_d = DONE;
               end else begin
                  drainCnt_d = drainCnt_q - 1'b1;
               end
            end
         end

         DONE: begin
            aOut0_d = '0;
            aOut1_d = '0;
            bOut0_d = '0;
            bOut1_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            aOut0_d = '0;
            aOut1_d = '0;
            bOut0_d = '0;
            bOut1_d = '0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Single state/output register bank. Reset is synchronous and
   // active-low. It discards any job in flight, including its latched
   // matrices, and parks every output at zero. ready then rises on the
   // first edge after release.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         drainCnt_q <= '0;
         matA_q     <= '0;
         matB_q     <= '0;
         aOut0_q    <= '0;
         aOut1_q    <= '0;
         bOut0_q    <= '0;
         bOut1_q    <= '0;
         valid_q    <= 1'b0;
         clear_q    <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         drainCnt_q <= drainCnt_d;
         matA_q     <= matA_d;
         matB_q     <= matB_d;
         aOut0_q    <= aOut0_d;
         aOut1_q    <= aOut1_d;
         bOut0_q    <= bOut0_d;
         bOut1_q    <= bOut1_d;
         valid_q    <= valid_d;
         clear_q    <= clear_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
      end
   end

   assign ready     = ready_q;
   assign busy      = busy_q;
   assign acc_clear = clear_q;
   assign valid_out = valid_q;
   assign done      = done_q;
   assign a_out_0   = aOut0_q;
   assign a_out_1   = aOut1_q;
   assign b_out_0   = bOut0_q;
   assign b_out_1   = bOut1_q;

endmodule
